// File: rtl/uart_tx_queue_pkg.sv
// uart_tx_queue_pkg: console MMIO addresses and serializer state encoding
package uart_tx_queue_pkg;
  localparam logic [31:0] UART_TX_ADDR = 32'h8000_0004;
  localparam logic [31:0] UART_STAT_ADDR = 32'h8000_0008;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO that drops pushes while full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign drop = push && full;
  assign dout = mem[rp];
  assign level = cnt;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: FIFO-buffered 8N1 transmitter with busy/level/overflow status
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     clr_overflow,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic                     tx,
  output logic                     tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  uart_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift, head;
  logic empty, drop, term, pop;
  assign term = cnt == CW'(CLKS_PER_BIT - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && term));
  assign busy = !empty || state != IDLE;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(wr_en), .din(wr_data), .pop(pop),
    .dout(head), .full(full), .empty(empty), .drop(drop), .level(level)
  );
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
  end
  // every line level, including the stop bit, is held for a full baud period
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      cnt <= (state == IDLE || term) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (pop) begin
          shift <= head;
          tx <= 1'b0;
          state <= START;
        end
        START: if (term) begin
          tx <= shift[0];
          idx <= '0;
          state <= DATA;
        end
        DATA: if (term) begin
          shift <= shift >> 1;
          idx <= idx + 1'b1;
          tx <= idx == 3'd7 ? 1'b1 : shift[1];
          state <= idx == 3'd7 ? STOP : DATA;
        end
        STOP: if (term) begin
          tx_done <= 1'b1;
          shift <= pop ? head : shift;
          tx <= !pop;
          state <= pop ? START : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: randomized and directed checks against a frame-timeline model
module tb_uart_tx_queue;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  logic clk = 0, rst = 1, wr_en = 0, clr_overflow = 0;
  logic [7:0] wr_data = 0;
  logic full, busy, overflow, tx, tx_done;
  logic [$clog2(DEPTH):0] level;
  int n_tests = 0, n_fail = 0, cyc = 0, done_seen = 0;
  logic [7:0] mq[$];
  logic [7:0] m_byte = 0;
  bit m_act = 0, m_ovf = 0, m_done = 0;
  int m_k = 0;

  uart_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .clr_overflow(clr_overflow), .full(full), .level(level), .busy(busy),
    .overflow(overflow), .tx(tx), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // model: each popped byte owns a FRAME-cycle window; position k picks the line level
  task automatic tick();
    bit full_pre, e_tx;
    full_pre = mq.size() == DEPTH;
    if (rst) begin
      mq.delete(); m_act = 0; m_k = 0; m_ovf = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_act && m_k == FRAME - 1) begin m_done = 1; m_act = 0; end
      else if (m_act) m_k++;
      if (!m_act && mq.size() > 0) begin m_byte = mq.pop_front(); m_act = 1; m_k = 0; end
      if (wr_en && !full_pre) mq.push_back(wr_data);
      m_ovf = (wr_en && full_pre) ? 1'b1 : clr_overflow ? 1'b0 : m_ovf;
    end
    @(posedge clk); #1;
    cyc++;
    e_tx = !m_act ? 1'b1 : m_k < CPB ? 1'b0 : m_k >= 9 * CPB ? 1'b1 : m_byte[m_k / CPB - 1];
    if (tx_done === 1'b1) done_seen++;
    n_tests += 6;
    if (tx !== e_tx) begin n_fail++; $display("FAIL tx cyc=%0d got=%b exp=%b", cyc, tx, e_tx); end
    if (tx_done !== m_done) begin n_fail++; $display("FAIL tx_done cyc=%0d got=%b exp=%b", cyc, tx_done, m_done); end
    if (level !== ($clog2(DEPTH)+1)'(mq.size())) begin n_fail++; $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, level, mq.size()); end
    if (full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL full cyc=%0d got=%b exp=%b", cyc, full, mq.size() == DEPTH); end
    if (busy !== (m_act || mq.size() > 0)) begin n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_act || mq.size() > 0); end
    if (overflow !== m_ovf) begin n_fail++; $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf); end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1; wr_data = b; tick(); wr_en = 0;
  endtask

  task automatic drain();
    int g = 0;
    while ((m_act || mq.size() > 0) && g < FRAME * (DEPTH + 3)) begin tick(); g++; end
    n_tests++;
    if (m_act || mq.size() > 0) begin n_fail++; $display("FAIL drain_timeout got=%0d exp<%0d", g, FRAME * (DEPTH + 3)); end
    repeat (3) tick();
  endtask

  task automatic wait_k(input int k);
    int g = 0;
    while (!(m_act && m_k == k) && g < FRAME * (DEPTH + 3)) begin tick(); g++; end
    n_tests++;
    if (!(m_act && m_k == k)) begin n_fail++; $display("FAIL wait_k got=%0d exp=%0d", m_k, k); end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_tests += 6;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", tx); end
    if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
    if (level !== 0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single();
    int d0 = done_seen, low = 0;
    push(8'hA5);
    for (int i = 1; i <= 41; i++) begin
      tick();
      if (i <= 4 && tx === 1'b0) low++;
    end
    n_tests += 3;
    if (low !== 4) begin n_fail++; $display("FAIL single_start_len got=%0d exp=4", low); end
    if (done_seen - d0 !== 1) begin n_fail++; $display("FAIL single_done got=%0d exp=1", done_seen - d0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int d0 = done_seen, pk = 0;
    wr_en = 1;
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'(i); tick();
      if (int'(level) > pk) pk = int'(level);
    end
    wr_en = 0;
    drain();
    n_tests += 2;
    if (pk !== 2) begin n_fail++; $display("FAIL b2b_peak_level got=%0d exp=2", pk); end
    if (done_seen - d0 !== 3) begin n_fail++; $display("FAIL b2b_done got=%0d exp=3", done_seen - d0); end
  endtask

  task automatic test_overflow();
    wr_en = 1;
    for (int i = 0; i < 6; i++) begin wr_data = 8'($urandom); tick(); end
    wr_en = 0;
    n_tests += 3;
    if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b exp=1", full); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    if (level !== 4) begin n_fail++; $display("FAIL ovf_level got=%0d exp=4", level); end
    clr_overflow = 1; tick(); clr_overflow = 0;
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pop();
    wait_k(FRAME - 1);
    push(8'hEE);
    n_tests += 3;
    if (level !== DEPTH - 1) begin n_fail++; $display("FAIL fullpop_level got=%0d exp=%0d", level, DEPTH - 1); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL fullpop_overflow got=%b exp=1", overflow); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL fullpop_full got=%b exp=0", full); end
    clr_overflow = 1; tick(); clr_overflow = 0;
    drain();
  endtask

  task automatic test_mid_reset();
    push(8'($urandom));
    push(8'($urandom));
    wait_k(4 * CPB + 1);
    rst = 1; tick(); rst = 0;
    n_tests += 3;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx got=%b exp=1", tx); end
    if (level !== 0) begin n_fail++; $display("FAIL midrst_level got=%0d exp=0", level); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    push(8'h55);
    drain();
  endtask

  task automatic test_ff00();
    int d0 = done_seen;
    push(8'hFF); push(8'h00);
    drain();
    n_tests++;
    if (done_seen - d0 !== 2) begin n_fail++; $display("FAIL ff00_done got=%0d exp=2", done_seen - d0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      wr_en = $urandom_range(0, 29) == 0;
      wr_data = 8'($urandom);
      clr_overflow = $urandom_range(0, 99) == 0;
      tick();
    end
    wr_en = 0; clr_overflow = 0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    test_ff00();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Buffered UART transmit path for the MMIO console. It consumes byte writes that the data memory decodes at 0x8000_0004 and queues them in a small FIFO. A serializer drains the FIFO as 8N1 frames on the TX pin. Its busy/level status feeds the UART status read at 0x8000_0008, so software no longer loses bytes written while a frame is in flight.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (must be >= 2)
DEPTH, 16, FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_en  in  1  push request (one cycle per byte)
wr_data  in  8  byte to transmit
clr_overflow  in  1  clears the sticky overflow flag
full  out  1  FIFO holds DEPTH entries
level  out  $clog2(DEPTH)+1  current FIFO occupancy
busy  out  1  FIFO non-empty OR serializer not IDLE
overflow  out  1  sticky: a push was dropped because the FIFO was full
tx  out  1  serial line, idle high
tx_done  out  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FIFO empty, level=0, full=0, busy=0, overflow=0, tx=1, tx_done=0, state=IDLE, baud counter=0, bit index=0.
- Reset asserted mid-frame aborts the frame. tx returns high on the next edge and queued bytes are discarded.
- FIFO pushes:
  - A push is accepted at edge E when wr_en=1 and full=0 (evaluated before that edge). level increments after E.
  - wr_en=1 with full=1: the byte is dropped and overflow is set after E. This holds even if a pop occurs at the same edge; there is no pop-then-push when full.
- Simultaneous push and pop with the FIFO not full: both occur and level is unchanged.
- Overflow flag: clr_overflow=1 clears it. If a drop and clr_overflow coincide, set wins.
- full = (level==DEPTH). Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Serializer FSM: IDLE, START, DATA, STOP.
  - IDLE: if level>0 at edge E, pop the head into the shift register, set tx<=0, set the baud counter to 0 and go to START. There is no bypass: a byte pushed at edge E pops at E+1, so tx falls after E+1.
  - Baud counter counts 0..CLKS_PER_BIT-1. Every line level is held exactly CLKS_PER_BIT cycles.
  - START: at terminal count, tx<=shift[0], bit index=0, go to DATA.
  - DATA: at terminal count, shift right and increment the index. After bit 7's period, tx<=1 and go to STOP. Bits are sent LSB first.
  - STOP: at terminal count, tx_done<=1 for one cycle. If level>0, pop immediately, tx<=0 and go to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE with tx=1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Consecutive queued frames start exactly 10*CLKS_PER_BIT cycles apart.
- tx and tx_done are registered outputs; level, full and busy derive from registers.
- Producer contract: the producer polls busy or full. It is never stalled by this block.

Decomposition:
- riscv_pkg gains:
  - UART_TX_ADDR = 32'h8000_0004 and UART_STAT_ADDR = 32'h8000_0008 constants.
  - uart_state_t enum {IDLE, START, DATA, STOP}.
- One natural sub-module, sync_fifo: parameterised WIDTH/DEPTH, with push/pop/full/empty/level and drop-on-full.
- The serializer FSM stays in uart_tx_queue.
- The data memory replaces its direct UART instance with this block. The status read returns {full, busy} in bits [1:0].

Test Plan:
1. CLKS_PER_BIT=4. Push 0xA5 at edge E -> tx low for edges E+1..E+4. Then bits 1,0,1,0,0,1,0,1 each for 4 cycles. Stop high from E+37. tx_done pulses after E+41. busy drops after E+41.
2. Push 0x01, 0x02, 0x03 on consecutive cycles -> three frames with start bits exactly 40 cycles apart and no idle gap. tx_done fires three times. level peaks at 2.
3. DEPTH=4, serializer held busy by the first frame. Push 6 bytes back-to-back -> 5 accepted (1 popped plus 4 queued), 6th dropped. full=1, overflow=1. Pulse clr_overflow -> overflow=0; transmitted byte sequence excludes the dropped byte.
4. Assert rst during DATA bit 3 -> tx=1, level=0, busy=0 and state IDLE after that edge. A subsequent push 0x55 transmits a clean frame.
5. With full=1, apply wr_en=1 on the same edge the STOP→START pop occurs -> byte dropped, overflow=1, level=DEPTH-1 afterwards.
6. Push 0xFF then 0x00 -> line shows start, 8 high, stop, then start, 8 low, stop. Bit-period count is 4 for every level.
